reqack_tph_tx: RTL and testbench

Transmitter endpoint for the two-phase (transition-signalled) request/acknowledge protocol. It accepts words on a local valid/ready push interface, buffers them in a small FIFO, and launches one two-phase transfer per word toward a `req`/`ack` pipeline stage or receiver. An optional two-flop synchronizer on `ack` allows the far end to sit in another clock domain. A sticky error flag reports protocol violations by the far end.

---
 rtl/reqack_tph_tx.sv | 119 +++++++++++
 tb/tb_reqack_tph_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reqack_tph_tx.sv
// Two-phase req/ack transmitter endpoint.
// Buffers local pushes in a FIFO and launches one toggle-signalled transfer per word.
module reqack_tph_tx #(
  parameter int DWIDTH          = 1,
  parameter int DEPTH           = 2,
  parameter bit INCLUDE_CDC_ACK = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [DWIDTH-1:0]        i_dat,
  output logic                     req,
  input  logic                     ack,
  output logic [DWIDTH-1:0]        o_dat,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t state, state_n;

  logic ack_i;

  generate
    if (INCLUDE_CDC_ACK) begin : g_cdc
      logic [1:0] sync;
      always_ff @(posedge clk) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {ack, sync[1]};
      end
      assign ack_i = sync[0];
    end else begin : g_nocdc
      assign ack_i = ack;
    end
  endgenerate

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              launch;
  logic              err_set;

  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign empty   = (wr_ptr == rd_ptr);
  assign i_ready = rst_n & ~full;
  assign wr_en   = i_valid & i_ready;
  assign o_level = wr_ptr - rd_ptr;
  assign o_busy  = (state == BUSY);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= i_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (launch) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Far-end ack mismatch while idle is checked before any launch.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (ack_i != req) begin
          state_n = ERR;
          err_set = 1'b1;
        end else if (!empty) begin
          launch  = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (ack_i == req) begin
          if (!empty) launch = 1'b1;
          else        state_n = IDLE;
        end
      end
      ERR: state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req   <= 1'b0;
      o_dat <= '0;
      o_err <= 1'b0;
    end else begin
      state <= state_n;
      if (launch) begin
        req   <= ~req;
        o_dat <= mem[rd_ptr[AW-1:0]];
      end
      if (err_set) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reqack_tph_tx.sv
// Directed bench for reqack_tph_tx with a data scoreboard.
// A second instance with the ack synchronizer shares the stimulus.
module tb_reqack_tph_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid;
  logic [3:0] i_dat;
  logic       ack;

  logic       i_ready0, req0, busy0, err0;
  logic [3:0] o_dat0;
  logic [1:0] lvl0;
  logic       i_ready1, req1, busy1, err1;
  logic [3:0] o_dat1;
  logic [1:0] lvl1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [3:0] sb [$];
  int         tcyc [$];
  logic       last_req = 1'b0;
  logic       req_d    = 1'b0;
  logic       echo     = 1'b0;
  logic       last_fire;

  always #5 clk = ~clk;

  reqack_tph_tx #(.DWIDTH(4), .DEPTH(2), .INCLUDE_CDC_ACK(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready0),
    .i_dat(i_dat), .req(req0), .ack(ack), .o_dat(o_dat0),
    .o_level(lvl0), .o_busy(busy0), .o_err(err0)
  );

  reqack_tph_tx #(.DWIDTH(4), .DEPTH(2), .INCLUDE_CDC_ACK(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready1),
    .i_dat(i_dat), .req(req1), .ack(ack), .o_dat(o_dat1),
    .o_level(lvl1), .o_busy(busy1), .o_err(err1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic fire;
    logic live;
    logic [3:0] d;
    logic [3:0] e;
    fire = i_valid && i_ready0;
    live = rst_n;
    d    = i_dat;
    @(posedge clk);
    #1;
    cyc++;
    if (live) begin
      if (fire) sb.push_back(d);
      if (req0 !== last_req) begin
        tcyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("launch_without_word", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("o_dat_order", int'(o_dat0), int'(e));
        end
      end
    end
    last_fire = fire;
    last_req  = req0;
    if (echo) ack = req_d;
    req_d = req0;
  endtask

  task automatic wr_step(input logic [3:0] d);
    i_valid = 1'b1;
    i_dat   = d;
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    logic       sreq;
    logic [3:0] sdat;
    int lat0, lat1;

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_dat   = 4'h0;
    ack     = 1'b0;
    step();
    step();
    chk("rst_i_ready_low", int'(i_ready0), 0);
    rst_n = 1'b1;
    step();
    chk("rst_req", int'(req0), 0);
    chk("rst_o_dat", int'(o_dat0), 0);
    chk("rst_level", int'(lvl0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_i_ready", int'(i_ready0), 1);

    // single word
    wr_step(4'h5);
    chk("single_level", int'(lvl0), 1);
    chk("single_req_wait", int'(req0), 0);
    step();
    chk("single_req", int'(req0), 1);
    chk("single_busy", int'(busy0), 1);
    chk("single_dat", int'(o_dat0), 5);
    ack = 1'b1;
    step();
    chk("single_idle", int'(busy0), 0);
    chk("single_no_err", int'(err0), 0);

    // back-to-back into a full FIFO
    tcyc.delete();
    wr_step(4'hA);
    i_valid = 1'b1;
    i_dat   = 4'hB;
    step();
    chk("b2b_launch_a", int'(o_dat0), 10);
    i_dat = 4'hC;
    step();
    chk("b2b_level_full", int'(lvl0), 2);
    chk("b2b_ready_low", int'(i_ready0), 0);
    i_dat = 4'hD;
    step();
    chk("b2b_stall_level", int'(lvl0), 2);
    chk("b2b_hold_req", int'(req0), 0);
    chk("b2b_hold_busy", int'(busy0), 1);
    echo = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (last_fire) i_valid = 1'b0;
      if (!i_valid && tcyc.size() >= 4 && !busy0) break;
    end
    echo = 1'b0;
    chk("b2b_toggles", tcyc.size(), 4);
    if (tcyc.size() >= 4) begin
      chk("b2b_gap_bc", tcyc[2] - tcyc[1], 2);
      chk("b2b_gap_cd", tcyc[3] - tcyc[2], 2);
    end
    chk("b2b_level_end", int'(lvl0), 0);
    chk("b2b_busy_end", int'(busy0), 0);

    // simultaneous write and pop
    wr_step(4'h1);
    chk("sim_level_pre", int'(lvl0), 1);
    wr_step(4'h2);
    chk("sim_level_launch", int'(lvl0), 1);
    chk("sim_busy", int'(busy0), 1);
    ack = req0;
    wr_step(4'h3);
    chk("sim_level_complete", int'(lvl0), 1);
    chk("sim_dat_2", int'(o_dat0), 2);
    echo = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!busy0 && lvl0 == 0) break;
    end
    echo = 1'b0;
    chk("sim_drained", int'(lvl0), 0);
    chk("sim_sb_empty", sb.size(), 0);
    chk("sim_last_dat", int'(o_dat0), 3);

    // spurious ack in idle
    sreq = req0;
    sdat = o_dat0;
    ack  = ~ack;
    step();
    chk("spur_err", int'(err0), 1);
    chk("spur_busy", int'(busy0), 0);
    wr_step(4'h6);
    wr_step(4'h7);
    wr_step(4'h8);
    chk("spur_level", int'(lvl0), 2);
    chk("spur_ready", int'(i_ready0), 0);
    for (int k = 0; k < 5; k++) begin
      ack = ~ack;
      step();
    end
    chk("spur_req_frozen", int'(req0), int'(sreq));
    chk("spur_dat_frozen", int'(o_dat0), int'(sdat));
    chk("spur_err_sticky", int'(err0), 1);

    // reset clears error and FIFO
    rst_n = 1'b0;
    ack   = 1'b0;
    step();
    chk("rst2_ready_low", int'(i_ready0), 0);
    chk("rst2_err", int'(err0), 0);
    chk("rst2_level", int'(lvl0), 0);
    chk("rst2_req", int'(req0), 0);
    sb.delete();
    last_req = req0;
    req_d    = req0;
    rst_n = 1'b1;
    step();
    chk("rst2_ready", int'(i_ready0), 1);

    // ack synchronizer latency
    wr_step(4'h9);
    step();
    chk("cdc_req", int'(req1), 1);
    chk("cdc_busy", int'(busy1), 1);
    chk("cdc_dat", int'(o_dat1), 9);
    ack  = 1'b1;
    lat0 = 0;
    lat1 = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (!busy0 && lat0 == 0) lat0 = k;
      if (!busy1 && lat1 == 0) lat1 = k;
      if (lat0 != 0 && lat1 != 0) break;
    end
    chk("cdc_lat_direct", lat0, 1);
    chk("cdc_lat_sync", lat1, 3);
    chk("cdc_extra", lat1 - lat0, 2);
    chk("cdc_no_err", int'(err1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
